// File: rtl/uart_cmd_frame_parser.sv
// UART command-frame parser: assembles read/write frames from received bytes
// and hands validated commands and burst payload words to the DDR2 user port.
module uart_cmd_frame_parser #(
    parameter int          ADDR_WIDTH  = 26,
    parameter int          ADDR_BYTES  = 4,
    parameter int          WORD_WIDTH  = 16,
    parameter int          BURST_LEN   = 8,
    parameter logic [7:0]  CMD_WR      = 8'h01,
    parameter logic [7:0]  CMD_RD      = 8'h02,
    parameter logic [7:0]  EOF_BYTE    = 8'hFF,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_wr,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  wdata_valid,
    input  logic                  wdata_ready,
    output logic [WORD_WIDTH-1:0] wdata,
    output logic                  wdata_last,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int BPW  = WORD_WIDTH / 8;
    localparam int BMAX = (ADDR_BYTES > BPW) ? ADDR_BYTES : BPW;
    localparam int BCW  = $clog2(BMAX + 1);
    localparam int WCW  = $clog2(BURST_LEN + 1);
    localparam int WIX  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int TCW  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_EOF    = 3'd3;
    localparam logic [2:0] S_ISSUE  = 3'd4;
    localparam logic [2:0] S_STREAM = 3'd5;

    logic [2:0]            state;
    logic [BCW-1:0]        byte_cnt;
    logic [WCW-1:0]        word_cnt;
    logic [TCW-1:0]        tmo_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [WIX-1:0]        widx;
    logic [WORD_WIDTH-1:0] mem [BURST_LEN];

    assign widx        = word_cnt[WIX-1:0];
    assign busy        = (state != S_IDLE);
    assign cmd_valid   = (state == S_ISSUE);
    assign cmd_wr      = wr_q;
    assign cmd_addr    = addr_q;
    assign wdata_valid = (state == S_STREAM);
    assign wdata       = wdata_valid ? mem[widx] : '0;
    assign wdata_last  = wdata_valid && (word_cnt == WCW'(BURST_LEN - 1));

    // Payload buffer needs no reset: wdata is masked until STREAM.
    always_ff @(posedge sys_clk) begin
        if (state == S_DATA && rx_valid) begin
            for (int i = 0; i < BPW; i++) begin
                if (byte_cnt == BCW'(i)) begin
                    mem[widx][i*8 +: 8] <= rx_data;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            tmo_cnt   <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    tmo_cnt  <= '0;
                    if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                        wr_q  <= (rx_data == CMD_WR);
                        state <= S_ADDR;
                    end
                end
                S_ADDR, S_DATA, S_EOF: begin
                    // A byte in the same cycle as expiry keeps the frame alive.
                    if (rx_valid) begin
                        tmo_cnt <= '0;
                        if (state == S_ADDR) begin
                            addr_q <= ADDR_WIDTH'({addr_q, rx_data});
                            if (byte_cnt == BCW'(ADDR_BYTES - 1)) begin
                                byte_cnt <= '0;
                                state    <= wr_q ? S_DATA : S_EOF;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end else if (state == S_DATA) begin
                            if (byte_cnt == BCW'(BPW - 1)) begin
                                byte_cnt <= '0;
                                if (word_cnt == WCW'(BURST_LEN - 1)) begin
                                    word_cnt <= '0;
                                    state    <= S_EOF;
                                end else begin
                                    word_cnt <= word_cnt + 1'b1;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end else if (rx_data == EOF_BYTE) begin
                            state <= S_ISSUE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                            byte_cnt  <= '0;
                            word_cnt  <= '0;
                        end
                    end else if (tmo_cnt == TCW'(TIMEOUT_CYC)) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                        byte_cnt  <= '0;
                        word_cnt  <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    overrun <= rx_valid;
                    if (cmd_ready) begin
                        state <= wr_q ? S_STREAM : S_IDLE;
                    end
                end
                S_STREAM: begin
                    overrun <= rx_valid;
                    if (wdata_ready) begin
                        if (word_cnt == WCW'(BURST_LEN - 1)) begin
                            word_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Directed bench for uart_cmd_frame_parser: write/read frames, bad terminator,
// timeout, command back-pressure with overrun, and reset mid-stream.
module tb_uart_cmd_frame_parser;

    localparam int TO = 300;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_ready = 1'b1;
    logic        wdata_ready = 1'b1;
    logic        cmd_valid;
    logic        cmd_wr;
    logic [25:0] cmd_addr;
    logic        wdata_valid;
    logic [15:0] wdata;
    logic        wdata_last;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    uart_cmd_frame_parser #(.TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata(wdata), .wdata_last(wdata_last),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_cmd = 0;
    int n_words = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_unstable = 0;
    logic        cwr_log [$];
    logic [25:0] cad_log [$];
    logic [15:0] w_log [$];
    logic        l_log [$];
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pw = 1'b0;
    logic [25:0] pa = '0;

    // Samples mid-cycle what the next rising edge will see.
    always @(negedge sys_clk) begin
        #2;
        if (cmd_valid && cmd_ready) begin
            n_cmd++;
            cwr_log.push_back(cmd_wr);
            cad_log.push_back(cmd_addr);
        end
        if (wdata_valid && wdata_ready) begin
            n_words++;
            w_log.push_back(wdata);
            l_log.push_back(wdata_last);
        end
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (pv && !pr && (!cmd_valid || cmd_addr != pa || cmd_wr != pw))
            n_unstable++;
        pv = cmd_valid;
        pr = cmd_ready;
        pa = cmd_addr;
        pw = cmd_wr;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge sys_clk);
            #1;
            if (!busy) break;
        end
    endtask

    logic [7:0]  pay [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                              8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC,
                              8'hDD, 8'hEE, 8'h11, 8'h22};
    logic [15:0] exp_w [8] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877,
                               16'hAA99, 16'hCCBB, 16'hEEDD, 16'h2211};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, f0, o0, u0;
        logic [7:0] lm;

        repeat (3) @(negedge sys_clk);
        #1;
        check("rst_ctl", {25'd0, cmd_valid, cmd_wr, wdata_valid, wdata_last,
                          busy, frame_err, overrun}, 32'd0);
        check("rst_addr", {6'd0, cmd_addr}, 32'd0);
        check("rst_wdata", {16'd0, wdata}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_cycles(2);

        // Write frame, address 0, ready held high
        c0 = n_cmd;
        w0 = n_words;
        send_byte(8'h01);
        repeat (4) send_byte(8'h00);
        for (int i = 0; i < 16; i++) send_byte(pay[i]);
        send_byte(8'hFF);
        #1;
        check("wr_cmd_lat", {31'd0, cmd_valid}, 32'd1);
        @(negedge sys_clk);
        #1;
        check("wr_wd_lat", {31'd0, wdata_valid}, 32'd1);
        wait_idle(40);
        wait_cycles(2);
        check("wr_ncmd", n_cmd - c0, 1);
        check("wr_cmd_wr", {31'd0, cwr_log[c0]}, 32'd1);
        check("wr_cmd_addr", {6'd0, cad_log[c0]}, 32'd0);
        check("wr_nwords", n_words - w0, 8);
        lm = '0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wr_word%0d", i), {16'd0, w_log[w0+i]}, {16'd0, exp_w[i]});
            lm[i] = l_log[w0+i];
        end
        check("wr_last", {24'd0, lm}, 32'h80);
        check("wr_busy", {31'd0, busy}, 32'd0);

        // Stray byte in IDLE, then read frame
        send_byte(8'h55);
        #1;
        check("idle_ignore", {31'd0, busy}, 32'd0);
        c0 = n_cmd;
        w0 = n_words;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'hFF);
        wait_idle(20);
        wait_cycles(2);
        check("rd_ncmd", n_cmd - c0, 1);
        check("rd_cmd_wr", {31'd0, cwr_log[c0]}, 32'd0);
        check("rd_cmd_addr", {6'd0, cad_log[c0]}, 32'h0123456);
        check("rd_nowords", n_words - w0, 0);

        // Bad terminator, then a good read frame
        c0 = n_cmd;
        f0 = n_ferr;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'hFE);
        wait_cycles(3);
        #1;
        check("bad_ferr", n_ferr - f0, 1);
        check("bad_nocmd", n_cmd - c0, 0);
        check("bad_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'hFF);
        wait_idle(20);
        wait_cycles(2);
        check("bad_next_ncmd", n_cmd - c0, 1);
        check("bad_next_addr", {6'd0, cad_log[c0]}, 32'h7);

        // Inter-byte timeout
        c0 = n_cmd;
        f0 = n_ferr;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_cycles(TO - 10);
        #1;
        check("to_early_busy", {31'd0, busy}, 32'd1);
        check("to_early_ferr", n_ferr - f0, 0);
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            #3;
            if (n_ferr != f0) break;
        end
        wait_cycles(2);
        #1;
        check("to_ferr", n_ferr - f0, 1);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_nocmd", n_cmd - c0, 0);

        // Command back-pressure with an overrun byte
        c0 = n_cmd;
        o0 = n_ovr;
        u0 = n_unstable;
        cmd_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hFF);
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            rx_valid = (i == 10);
            rx_data  = 8'h02;
        end
        #1;
        check("bp_hold", {31'd0, cmd_valid}, 32'd1);
        check("bp_ovr", n_ovr - o0, 1);
        check("bp_nocmd", n_cmd - c0, 0);
        @(negedge sys_clk);
        cmd_ready = 1'b1;
        wait_idle(10);
        wait_cycles(2);
        check("bp_ncmd", n_cmd - c0, 1);
        check("bp_addr", {6'd0, cad_log[c0]}, 32'hABCD);
        check("bp_stable", n_unstable - u0, 0);

        // Reset after the third payload handshake
        c0 = n_cmd;
        w0 = n_words;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(pay[i]);
        send_byte(8'hFF);
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            #3;
            if (n_words - w0 >= 3) break;
        end
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        #2;
        check("rstm_ctl", {25'd0, cmd_valid, cmd_wr, wdata_valid, wdata_last,
                           busy, frame_err, overrun}, 32'd0);
        check("rstm_addr", {6'd0, cmd_addr}, 32'd0);
        check("rstm_wdata", {16'd0, wdata}, 32'd0);
        wait_cycles(3);
        sys_rst_n = 1'b1;
        wait_cycles(30);
        #1;
        check("rstm_nwords", n_words - w0, 3);
        check("rstm_ncmd", n_cmd - c0, 1);
        check("rstm_busy", {31'd0, busy}, 32'd0);
        check("rstm_wvalid", {31'd0, wdata_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_frame_parser.md
# uart_cmd_frame_parser

Parametrised UART command-frame parser between the byte-level UART receiver and the DDR2 controller user port in the UART-to-DDR2 bring-up design. Assembles write frames (command, address, burst payload, terminator) and read frames (command, address, terminator) from received bytes. Issues one validated command per frame on a valid/ready port and streams write payload words on a second valid/ready port. Frame length, address width, word width, burst length and byte codes are generic; malformed frames, inter-byte timeouts and overruns are detected and reported.

## Interface
- ADDR_WIDTH, 26: DDR2 address width, bank + row + column.
- ADDR_BYTES, 4: address bytes per frame, MSB first; requires ADDR_BYTES*8 >= ADDR_WIDTH.
- WORD_WIDTH, 16: payload word width; must be a multiple of 8.
- BURST_LEN, 8: words per write frame.
- CMD_WR, 8'h01: write command byte.
- CMD_RD, 8'h02: read command byte.
- EOF_BYTE, 8'hFF: frame terminator.
- TIMEOUT_CYC, 100000: maximum sys_clk cycles between bytes inside a frame.

Ports:
- sys_clk  in  1  system clock; only clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse per received UART byte.
- rx_data  in  8  received byte; valid when rx_valid is high.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  controller accepts the command.
- cmd_wr  out  1  1 = write, 0 = read.
- cmd_addr  out  ADDR_WIDTH  command address.
- wdata_valid  out  1  payload word available.
- wdata_ready  in  1  controller accepts the word.
- wdata  out  WORD_WIDTH  payload word.
- wdata_last  out  1  marks the final word of the burst.
- busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse when a frame is dropped.
- overrun  out  1  one-cycle pulse when a byte arrives while the block cannot accept it.

## Operation
States are IDLE, ADDR, DATA, EOF, ISSUE and STREAM.

- **IDLE:**
  - A CMD_WR or CMD_RD byte latches cmd_wr and enters ADDR.
  - Any other byte is silently ignored.
- **ADDR:**
  - Shifts in ADDR_BYTES bytes, MSB first.
  - cmd_addr takes the low ADDR_WIDTH bits; excess high bits are discarded.
  - After the last byte: write goes to DATA, read goes to EOF.
- **DATA:**
  - Receives BURST_LEN*WORD_WIDTH/8 bytes into the internal buffer.
  - Within each word the first byte is the least significant.
  - Words are stored in arrival order. Then enters EOF.
- **EOF:**
  - A byte equal to EOF_BYTE enters ISSUE.
  - Any other byte pulses frame_err and returns to IDLE. Nothing is issued.
- **ISSUE:**
  - cmd_valid is high, with cmd_wr and cmd_addr held stable.
  - On cmd_valid & cmd_ready: a write enters STREAM, a read enters IDLE.
- **STREAM:**
  - Presents buffer words 0..BURST_LEN-1 on wdata, advancing on each wdata_valid & wdata_ready.
  - wdata_last is high with word BURST_LEN-1.
  - Returns to IDLE after the last handshake.

Timeout and overrun:
- In ADDR, DATA and EOF, an idle-cycle counter is cleared on every rx_valid.
- When the counter reaches TIMEOUT_CYC, frame_err pulses and the state returns to IDLE.
- In ISSUE and STREAM, rx_valid pulses overrun and the byte is dropped.
- Byte counters and word counters are sized with $clog2 of their maximum plus 1. They clear on every entry to IDLE.

## Timing
- Reset values: cmd_valid, cmd_wr, wdata_valid, wdata_last, busy, frame_err and overrun are 0; cmd_addr and wdata are 0. State is IDLE and all counters are 0.
- Reset asserted mid-frame or mid-stream aborts immediately. No partial command or word is emitted after release.
- **Command latency:** cmd_valid rises in the cycle after the sys_clk edge that samples the EOF byte.
- **Payload latency:** first wdata_valid rises in the cycle after the cmd handshake cycle.
- wdata_valid stays high continuously until the last word is accepted, so one word transfers per cycle when wdata_ready is held high.
- busy falls in the cycle after the final handshake.
- valid never depends combinationally on ready. Outputs hold while valid is high and ready is low.
- frame_err and overrun are registered and are exactly one cycle wide.
- Timeout and an rx_valid arriving in the same cycle: the byte wins and the counter clears.

## Test plan
- **Write frame:** send bytes 01 00 00 00 00, then 11 22 33 44 55 66 77 88 99 AA BB CC DD EE 11 22, then FF; hold cmd_ready=1 and wdata_ready=1.
  - Expect one cmd with cmd_wr=1, cmd_addr=0.
  - Expect words 2211, 4433, 6655, 8877, AA99, CCBB, EEDD, 2211, with wdata_last on the 8th word only.
- **Read frame with address:** send 02 00 12 34 56 FF.
  - Expect cmd_wr=0, cmd_addr=26'h0123456, and no wdata_valid.
- **Bad terminator:** send a read frame ending in FE.
  - Expect a frame_err pulse, no cmd_valid, and IDLE afterwards.
  - A following valid read frame must issue normally.
- **Timeout:** send 01 00 00, then idle for TIMEOUT_CYC cycles.
  - Expect a frame_err pulse, busy=0, and no command.
- **Back-pressure and overrun:** hold cmd_ready=0 for 50 cycles after a read frame and inject byte 02 during the stall.
  - Expect an overrun pulse and cmd_valid stable throughout.
  - Exactly one command is issued once cmd_ready=1.
- **Reset mid-stream:** assert sys_rst_n=0 after the 3rd word handshake.
  - Expect all outputs at reset values.
  - No further wdata_valid after release.
